// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory arbiter: FSM state encoding, default
// parameters and a constant-foldable ceil(log2) helper.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_WRITE = 2'd3
  } arb_state_t;

  localparam int DEF_NUM_CH      = 2;
  localparam int DEF_ADDR_W      = 16;
  localparam int DEF_DATA_W      = 16;
  localparam int DEF_BLOCK_WORDS = 8;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after ptr,
// wrapping. Shared with the register-file port arbiter.
module rr_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int N = 2
) (
  input  logic [N-1:0]          req,
  input  logic [clog2(N)-1:0]   ptr,
  output logic [N-1:0]          gnt,
  output logic [clog2(N)-1:0]   idx
);

  localparam int IDX_W = clog2(N);

  logic [N-1:0] upper;
  logic [N-1:0] pick;

  // Requests at or above ptr win; only if none exist does the search wrap to bit 0.
  always_comb begin
    upper = '0;
    for (int i = 0; i < N; i++) begin
      upper[i] = req[i] && (IDX_W'(i) >= ptr);
    end
    pick = (|upper) ? upper : req;
  end

  always_comb begin
    gnt = '0;
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (pick[i]) begin
        gnt    = '0;
        gnt[i] = 1'b1;
        idx    = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter between NUM_CH cache controllers and one pipelined
// memory: block fills as burst reads, single-word write-through writes.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int NUM_CH      = DEF_NUM_CH,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int BLOCK_WORDS = DEF_BLOCK_WORDS
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_CH-1:0]             req_valid,
  input  logic [NUM_CH-1:0]             req_wr,
  input  logic [NUM_CH*ADDR_W-1:0]      req_addr,
  input  logic [NUM_CH*DATA_W-1:0]      req_wdata,
  output logic [NUM_CH-1:0]             grant,
  output logic [NUM_CH-1:0]             fill_valid,
  output logic [clog2(BLOCK_WORDS)-1:0] fill_word,
  output logic [DATA_W-1:0]             fill_data,
  output logic [NUM_CH-1:0]             done,
  output logic                          mem_en,
  output logic                          mem_wr,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [DATA_W-1:0]             mem_wdata,
  input  logic [DATA_W-1:0]             mem_rdata,
  input  logic                          mem_rvalid
);

  localparam int IDX_W  = clog2(NUM_CH);
  localparam int WORD_W = clog2(BLOCK_WORDS);
  localparam int CNT_W  = WORD_W + 1;
  localparam logic [CNT_W-1:0]  LAST_WORD  = CNT_W'(BLOCK_WORDS - 1);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(BLOCK_WORDS * 2 - 1);

  arb_state_t state, state_next;

  logic [IDX_W-1:0]  ptr, owner, arb_idx;
  logic [NUM_CH-1:0] arb_req, arb_gnt;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_data;
  logic [CNT_W-1:0]  issue_cnt, ret_cnt;
  logic              arb_hit, take_ret, last_ret, last_issue;

  logic [ADDR_W-1:0] addr_arr [NUM_CH];
  logic [DATA_W-1:0] data_arr [NUM_CH];

  for (genvar k = 0; k < NUM_CH; k++) begin : g_slice
    assign addr_arr[k] = req_addr[k*ADDR_W +: ADDR_W];
    assign data_arr[k] = req_wdata[k*DATA_W +: DATA_W];
  end

  // Grant is combinational in IDLE, so it must also be forced low while reset is held.
  assign arb_req = (state == ST_IDLE && !rst) ? req_valid : '0;

  rr_arbiter #(.N(NUM_CH)) u_rr (
    .req (arb_req),
    .ptr (ptr),
    .gnt (arb_gnt),
    .idx (arb_idx)
  );

  assign arb_hit    = |arb_gnt;
  assign take_ret   = mem_rvalid && (state == ST_ISSUE || state == ST_DRAIN);
  assign last_ret   = take_ret && (ret_cnt == LAST_WORD);
  assign last_issue = (state == ST_ISSUE) && (issue_cnt == LAST_WORD);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE:  if (arb_hit) state_next = req_wr[arb_idx] ? ST_WRITE : ST_ISSUE;
      ST_ISSUE: begin
        if (last_ret)        state_next = ST_IDLE;
        else if (last_issue) state_next = ST_DRAIN;
      end
      ST_DRAIN: if (last_ret) state_next = ST_IDLE;
      ST_WRITE: state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Fills keep the block-aligned base; writes keep the exact word address.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr       <= '0;
      owner     <= '0;
      lat_addr  <= '0;
      lat_data  <= '0;
      issue_cnt <= '0;
      ret_cnt   <= '0;
    end else begin
      if (arb_hit) begin
        owner     <= arb_idx;
        ptr       <= (arb_idx == IDX_W'(NUM_CH - 1)) ? '0 : arb_idx + 1'b1;
        lat_addr  <= req_wr[arb_idx] ? addr_arr[arb_idx] : (addr_arr[arb_idx] & ~ALIGN_MASK);
        lat_data  <= data_arr[arb_idx];
        issue_cnt <= '0;
        ret_cnt   <= '0;
      end
      if (state == ST_ISSUE) issue_cnt <= issue_cnt + 1'b1;
      if (take_ret)          ret_cnt   <= ret_cnt + 1'b1;
    end
  end

  always_comb begin
    grant      = arb_gnt;
    fill_valid = '0;
    fill_word  = '0;
    fill_data  = '0;
    done       = '0;
    mem_en     = 1'b0;
    mem_wr     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    if (state == ST_ISSUE) begin
      mem_en   = 1'b1;
      mem_addr = lat_addr + (ADDR_W'(issue_cnt) << 1);
    end
    if (state == ST_WRITE) begin
      mem_en      = 1'b1;
      mem_wr      = 1'b1;
      mem_addr    = lat_addr;
      mem_wdata   = lat_data;
      done[owner] = 1'b1;
    end
    if (take_ret) begin
      fill_valid[owner] = 1'b1;
      fill_word         = ret_cnt[WORD_W-1:0];
      fill_data         = mem_rdata;
      if (last_ret) done[owner] = 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: three configurations, each with a pipelined memory
// model and a transaction-level reference checked every cycle.
module tb_mem_arbiter;

  int checks   = 0;
  int failures = 0;
  logic clk = 1'b0;

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int cfg,
                             input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL cfg%0d %s: got 0x%0h, expected 0x%0h", cfg, name, actual, expected);
    end
  endtask

  function automatic logic [15:0] mem_fn(input logic [15:0] a);
    return 16'(a * 16'h9E37) ^ 16'h5A5A;
  endfunction

  for (genvar c = 0; c < 3; c++) begin : g_cfg
    localparam int NC        = (c == 0) ? 4 : 8;
    localparam int BW        = (c == 0) ? 8 : ((c == 1) ? 2 : 16);
    localparam int FIXED_LAT = (c == 0) ? 4 : 0;
    localparam int WW        = $clog2(BW);

    logic              rst;
    logic [NC-1:0]     req_valid, req_wr;
    logic [NC*16-1:0]  req_addr, req_wdata;
    logic [NC-1:0]     grant, fill_valid, done;
    logic [WW-1:0]     fill_word;
    logic [15:0]       fill_data, mem_addr, mem_wdata, mem_rdata;
    logic              mem_en, mem_wr, mem_rvalid;
    bit                fin = 1'b0;

    mem_arbiter #(.NUM_CH(NC), .ADDR_W(16), .DATA_W(16), .BLOCK_WORDS(BW)) u_dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_wr(req_wr),
      .req_addr(req_addr), .req_wdata(req_wdata), .grant(grant),
      .fill_valid(fill_valid), .fill_word(fill_word), .fill_data(fill_data),
      .done(done), .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid)
    );

    // Pipelined memory: a read issued in cycle n returns in cycle n+latency, in order.
    int          cyc = 0;
    int          last_due = 0;
    int          due_q[$];
    logic [15:0] dat_q[$];
    initial begin
      int lat, due;
      mem_rvalid = 1'b0;
      mem_rdata  = '0;
      forever begin
        @(negedge clk);
        if (rst) begin
          due_q.delete(); dat_q.delete(); last_due = 0;
        end else if (mem_en && !mem_wr) begin
          lat = (FIXED_LAT > 0) ? FIXED_LAT : int'($urandom_range(1, 6));
          due = cyc + lat;
          if (due <= last_due) due = last_due + 1;
          last_due = due;
          due_q.push_back(due);
          dat_q.push_back(mem_fn(mem_addr));
        end
        @(posedge clk); #1;
        cyc++;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        if (rst) begin
          due_q.delete(); dat_q.delete(); last_due = 0;
        end else if (due_q.size() > 0 && due_q[0] == cyc) begin
          mem_rvalid = 1'b1;
          mem_rdata  = dat_q[0];
          void'(due_q.pop_front());
          void'(dat_q.pop_front());
        end
      end
    end

    // Transaction-level reference: phase 0 idle, 1 write, 2 fill.
    int ph = 0, rr_ptr = 0, own = 0, issued = 0, returned = 0;
    int obs_grants = 0, obs_dones = 0;
    logic [15:0] base = '0, wa = '0, wd = '0;
    initial begin
      logic [NC-1:0] e_grant, e_fv, e_done;
      logic [WW-1:0] e_fw;
      logic [15:0]   e_fd, e_addr, e_wd, a;
      logic          e_en, e_wr;
      bit            found;
      forever begin
        @(negedge clk);
        e_grant = '0; e_fv = '0; e_done = '0; e_fw = '0; e_fd = '0;
        e_addr = '0; e_wd = '0; e_en = 1'b0; e_wr = 1'b0;
        if (rst) begin
          ph = 0; rr_ptr = 0;
        end else begin
          case (ph)
            0: begin
              found = 1'b0;
              for (int i = 0; i < NC; i++) begin
                if (!found && req_valid[(rr_ptr + i) % NC]) begin
                  found = 1'b1;
                  own = (rr_ptr + i) % NC;
                end
              end
              if (found) begin
                e_grant[own] = 1'b1;
                rr_ptr = (own + 1) % NC;
                a = req_addr[own*16 +: 16];
                if (req_wr[own]) begin
                  ph = 1; wa = a; wd = req_wdata[own*16 +: 16];
                end else begin
                  ph = 2; base = a & ~16'(BW * 2 - 1); issued = 0; returned = 0;
                end
              end
            end
            1: begin
              e_en = 1'b1; e_wr = 1'b1; e_addr = wa; e_wd = wd;
              e_done[own] = 1'b1;
              ph = 0;
            end
            default: begin
              if (issued < BW) begin
                e_en = 1'b1;
                e_addr = 16'(base + 16'(2 * issued));
                issued++;
              end
              if (mem_rvalid) begin
                e_fv[own] = 1'b1;
                e_fw = WW'(returned);
                e_fd = mem_fn(16'(base + 16'(2 * returned)));
                if (returned == BW - 1) begin
                  e_done[own] = 1'b1;
                  ph = 0;
                end
                returned++;
              end
            end
          endcase
        end
        obs_grants += $countones(grant);
        obs_dones  += $countones(done);
        checkOutput("grant", c, 32'(grant), 32'(e_grant));
        checkOutput("fill_valid", c, 32'(fill_valid), 32'(e_fv));
        checkOutput("fill_word", c, 32'(fill_word), 32'(e_fw));
        checkOutput("fill_data", c, 32'(fill_data), 32'(e_fd));
        checkOutput("done", c, 32'(done), 32'(e_done));
        checkOutput("mem_en", c, 32'(mem_en), 32'(e_en));
        checkOutput("mem_wr", c, 32'(mem_wr), 32'(e_wr));
        checkOutput("mem_addr", c, 32'(mem_addr), 32'(e_addr));
        checkOutput("mem_wdata", c, 32'(mem_wdata), 32'(e_wd));
      end
    end

    task automatic applyStimulus(input int ch, input logic wr,
                                 input logic [15:0] addr, input logic [15:0] data);
      @(posedge clk); #1;
      req_wr[ch]            = wr;
      req_addr[ch*16 +: 16] = addr;
      req_wdata[ch*16 +: 16] = data;
      req_valid[ch]         = 1'b1;
    endtask

    task automatic waitGrant(input int ch);
      bit ok;
      ok = 1'b0;
      for (int t = 0; t < 40 && !ok; t++) begin
        @(negedge clk);
        if (grant[ch]) ok = 1'b1;
      end
      checkOutput("grant_seen", c, 32'(ok), 32'd1);
      @(posedge clk); #1;
      req_valid[ch] = 1'b0;
    endtask

    if (c == 0) begin : g_directed
      initial begin
        int order[5];
        int exp_order[5];
        int n;
        bit hit;
        exp_order = '{0, 1, 2, 3, 0};
        rst = 1'b1; req_valid = '1; req_wr = '0; req_addr = '0; req_wdata = '0;
        @(negedge clk);
        checkOutput("reset_grant", c, 32'(grant), 32'd0);
        checkOutput("reset_mem_en", c, 32'(mem_en), 32'd0);
        req_valid = '0;
        @(posedge clk); #1; rst = 1'b0;

        // Single fill from ch0, memory latency 4.
        applyStimulus(0, 1'b0, 16'h0036, 16'h0000);
        waitGrant(0);
        for (int i = 1; i <= 12; i++) begin
          @(negedge clk);
          if (i <= 8) checkOutput("fill_issue_addr", c, 32'(mem_addr), 32'(16'h0030 + 16'(2 * (i - 1))));
          if (i >= 5) checkOutput("fill_word_order", c, 32'(fill_word), 32'(i - 5));
          checkOutput("fill_done", c, 32'(done), (i == 12) ? 32'h1 : 32'h0);
        end

        // Single write from ch1.
        applyStimulus(1, 1'b1, 16'h1002, 16'hBEEF);
        waitGrant(1);
        @(negedge clk);
        checkOutput("wr_mem_wr", c, 32'(mem_wr), 32'd1);
        checkOutput("wr_addr", c, 32'(mem_addr), 32'h1002);
        checkOutput("wr_data", c, 32'(mem_wdata), 32'hBEEF);
        checkOutput("wr_done", c, 32'(done), 32'h2);

        // Reset in the middle of a ch2 burst.
        applyStimulus(2, 1'b0, 16'h0100, 16'h0000);
        waitGrant(2);
        n = 0; hit = 1'b0;
        for (int t = 0; t < 20 && !hit; t++) begin
          @(negedge clk);
          if (fill_valid[2]) n++;
          if (n == 3) hit = 1'b1;
        end
        checkOutput("midburst_words", c, 32'(n), 32'd3);
        #1 rst = 1'b1;
        #1;
        checkOutput("rst_fill_valid", c, 32'(fill_valid), 32'd0);
        checkOutput("rst_fill_data", c, 32'(fill_data), 32'd0);
        checkOutput("rst_mem_en", c, 32'(mem_en), 32'd0);
        checkOutput("rst_mem_addr", c, 32'(mem_addr), 32'd0);
        checkOutput("rst_done", c, 32'(done), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        applyStimulus(1, 1'b0, 16'h2004, 16'h0000);
        waitGrant(1);
        for (int i = 1; i <= 12; i++) begin
          @(negedge clk);
          if (i == 1) checkOutput("refill_first_addr", c, 32'(mem_addr), 32'h2000);
          if (i == 5) checkOutput("refill_first_word", c, 32'(fill_word), 32'd0);
          checkOutput("refill_done", c, 32'(done), (i == 12) ? 32'h2 : 32'h0);
        end

        // All four channels request writes continuously from reset.
        @(posedge clk); #1;
        rst = 1'b1;
        for (int k = 0; k < NC; k++) begin
          req_addr[k*16 +: 16]  = 16'(16'h0010 * k);
          req_wdata[k*16 +: 16] = 16'(k);
        end
        req_wr = '1; req_valid = '1;
        @(posedge clk); #1; rst = 1'b0;
        n = 0;
        for (int t = 0; t < 40 && n < 5; t++) begin
          @(negedge clk);
          for (int k = 0; k < NC; k++) begin
            if (grant[k] && n < 5) begin order[n] = k; n++; end
          end
        end
        checkOutput("rr_count", c, 32'(n), 32'd5);
        for (int i = 0; i < 5; i++) checkOutput("rr_order", c, 32'(order[i]), 32'(exp_order[i]));
        @(posedge clk); #1; req_valid = '0;
        repeat (4) @(posedge clk);
        fin = 1'b1;
      end
    end else begin : g_sweep
      initial begin
        logic [NC-1:0] g;
        rst = 1'b1; req_valid = '0; req_wr = '0; req_addr = '0; req_wdata = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        for (int t = 0; t < 800; t++) begin
          @(negedge clk);
          g = grant;
          @(posedge clk); #1;
          for (int k = 0; k < NC; k++) begin
            if (req_valid[k] && g[k]) begin
              req_valid[k] = 1'b0;
            end else if (!req_valid[k] && $urandom_range(0, 2) == 0) begin
              req_wr[k]              = ($urandom_range(0, 3) == 0);
              req_addr[k*16 +: 16]  = 16'($urandom);
              req_wdata[k*16 +: 16] = 16'($urandom);
              req_valid[k]          = 1'b1;
            end
          end
        end
        req_valid = '0;
        repeat (100) @(posedge clk);
        checkOutput("done_per_grant", c, 32'(obs_dones), 32'(obs_grants));
        checkOutput("traffic_seen", c, 32'(obs_grants > 20), 32'd1);
        fin = 1'b1;
      end
    end
  end

  initial begin
    bit all_fin;
    all_fin = 1'b0;
    for (int t = 0; t < 5000 && !all_fin; t++) begin
      @(posedge clk);
      all_fin = g_cfg[0].fin && g_cfg[1].fin && g_cfg[2].fin;
    end
    checkOutput("all_finished", 0, 32'(all_fin), 32'd1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
